// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - iterative AES InvMixColumns engine with valid/ready handshake
//
// Takes one 128-bit AES state, multiplies each 32-bit column by the inverse
// MixColumns matrix over GF(2^8), COLS_PER_CYCLE columns per clock, and holds
// the result until downstream accepts it.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in         state in; byte k = in[8k +: 8], column c = bytes 4c..4c+3
//   in_valid   in is valid (sampled only in IDLE)
//   in_ready   high in IDLE
//   out        InvMixColumns result, same layout as in
//   out_valid  high in DONE
//   out_ready  downstream accepts out (sampled only in DONE)
//   busy       high in BUSY
`timescale 1ns/1ps

module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:127] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:127] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // STEP truncates 4 to 0, so with four columns per clock the counter stays at 0
  // and the single BUSY edge is also the last one.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [0:127] work_q, work_d;
  logic [0:127] out_q, out_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Products by 09/0b/0d/0e are sums of the x2/x4/x8 xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // One column unit per lane; lane j works on column cnt_q + j.
  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_a   [COLS_PER_CYCLE];
  logic [31:0] col_r   [COLS_PER_CYCLE];

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
    assign col_idx[j] = cnt_q + 2'(j);
    assign col_a[j]   = work_q[{col_idx[j], 5'b0} +: 32];
    assign col_r[j]   = inv_mix_col(col_a[j]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          work_d[{col_idx[j], 5'b0} +: 32] = col_r[j];
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST_CNT) begin
          // Result register is loaded only here, so out holds steady in IDLE/DONE.
          out_d   = work_d;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - self-checking bench for inv_mix_columns_seq at 1, 2 and 4 columns per clock
`timescale 1ns/1ps

module tb_inv_mix_columns_seq;

  localparam int ND = 3;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] V2 = 128'h4d7ebdf8_c6c6c6c6_01010101_00000000;
  localparam logic [127:0] E2 = 128'h2d26314c_c6c6c6c6_01010101_00000000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:127] din   [ND];
  logic [0:127] dout  [ND];
  logic         vin   [ND];
  logic         rdy   [ND];
  logic         irdy  [ND];
  logic         vout  [ND];
  logic         bsy   [ND];
  logic [127:0] exp_in[ND];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int got_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (din[g]),
      .in_valid (vin[g]),
      .in_ready (irdy[g]),
      .out      (dout[g]),
      .out_valid(vout[g]),
      .out_ready(rdy[g]),
      .busy     (bsy[g])
    );
  end

  // Reference GF(2^8) arithmetic: plain shift-and-add multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant column matrix with first row k; row i uses k rotated right by i.
  function automatic logic [127:0] circ(input logic [127:0] s, input logic [31:0] k);
    logic [127:0] r;
    logic [7:0]   acc;
    int           ki;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          ki  = (j - i + 4) % 4;
          acc = acc ^ gmul(k[31-8*ki -: 8], s[127-32*c-8*j -: 8]);
        end
        r[127-32*c-8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] s);
    return circ(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    return circ(s, 32'h02030101);
  endfunction

  function automatic int lat(input int d);
    return 4 >> d;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: every negedge, for every DUT.
  logic         pend [ND];
  logic         pv   [ND];
  logic         phs  [ND];
  logic [127:0] exp_out[ND];
  int           acc_cyc[ND];

  initial begin
    for (int d = 0; d < ND; d++) begin
      pend[d] = 1'b0; pv[d] = 1'b0; phs[d] = 1'b0; exp_out[d] = '0; acc_cyc[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (!rst_n) begin
          pend[d] = 1'b0; pv[d] = 1'b0; phs[d] = 1'b0;
        end else begin
          if (phs[d]) begin
            chk("valid_drops_after_handshake", vout[d], 1'b0);
            chk("ready_after_handshake", irdy[d], 1'b1);
          end
          if (pend[d] && !vout[d]) begin
            chk("busy_while_processing", bsy[d], 1'b1);
            chk("in_ready_while_processing", irdy[d], 1'b0);
          end
          if (vout[d]) begin
            if (!pend[d]) chk("unexpected_out_valid", vout[d], 1'b0);
            else          chk("out_data", dout[d], exp_out[d]);
            chk("in_ready_in_done", irdy[d], 1'b0);
            chk("busy_in_done", bsy[d], 1'b0);
            if (!pv[d]) chk("latency", 128'(cyc - acc_cyc[d]), 128'(lat(d)));
          end
          if (vin[d] && irdy[d]) begin
            if (pend[d]) chk("accept_while_pending", pend[d], 1'b0);
            exp_out[d] = exp_in[d];
            pend[d]    = 1'b1;
            acc_cyc[d] = cyc + 1;
          end
          phs[d] = vout[d] && rdy[d];
          if (phs[d]) begin
            pend[d] = 1'b0;
            got_total++;
          end
          pv[d] = vout[d];
        end
      end
    end
  end

  task automatic xfer(input int d, input logic [127:0] v, input logic [127:0] lit);
    int n;
    @(posedge clk); #1;
    din[d] = v; vin[d] = 1'b1; exp_in[d] = inv_model(v); rdy[d] = 1'b1;
    @(posedge clk); #1;
    vin[d] = 1'b0;
    n = 0;
    while (!vout[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!vout[d]) chk("xfer_timeout", vout[d], 1'b1);
    else          chk("xfer_literal", dout[d], lit);
    @(posedge clk); #1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         acc [ND];
    int           sent[ND];
    int           target;
    int           n;
    int           got_base;
    logic [127:0] orig;

    // Model pins.
    chk("model_inv_v1", inv_model(V1), E1);
    chk("model_inv_v2", inv_model(V2), E2);
    chk("model_fwd_e1", mix_model(E1), V1);

    // 1: reset with in_valid held high.
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      din[d] = V1; vin[d] = 1'b1; rdy[d] = 1'b1; exp_in[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("reset_in_ready", irdy[d], 1'b1);
      chk("reset_out_valid", vout[d], 1'b0);
      chk("reset_busy", bsy[d], 1'b0);
      chk("reset_out", dout[d], 128'h0);
      vin[d] = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      chk("no_accept_in_reset_busy", bsy[d], 1'b0);
      chk("no_accept_in_reset_ready", irdy[d], 1'b1);
    end

    // 2/3: directed vectors at each column width.
    for (int d = 0; d < ND; d++) begin
      xfer(d, V1, E1);
      xfer(d, V2, E2);
    end

    // 4: backpressure while in_valid and in toggle.
    @(posedge clk); #1;
    din[1] = V2; vin[1] = 1'b1; exp_in[1] = inv_model(V2); rdy[1] = 1'b0;
    @(posedge clk); #1;
    vin[1] = 1'b0;
    n = 0;
    while (!vout[1] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reached_done", vout[1], 1'b1);
    for (int i = 0; i < 10; i++) begin
      vin[1] = i[0];
      din[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      chk("bp_out_stable", dout[1], E2);
      chk("bp_in_ready_low", irdy[1], 1'b0);
      chk("bp_valid_held", vout[1], 1'b1);
    end
    vin[1] = 1'b0; rdy[1] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", irdy[1], 1'b1);
    chk("bp_release_valid", vout[1], 1'b0);

    // 5: async reset two BUSY cycles into a transform.
    @(posedge clk); #1;
    din[0] = V1; vin[0] = 1'b1; exp_in[0] = inv_model(V1);
    @(posedge clk); #1;
    vin[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("async_rst_in_ready", irdy[d], 1'b1);
      chk("async_rst_out_valid", vout[d], 1'b0);
      chk("async_rst_busy", bsy[d], 1'b0);
      chk("async_rst_out", dout[d], 128'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(0, V2, E2);

    // 6: round trip through the forward model with random gaps.
    got_base = got_total;
    for (int d = 0; d < ND; d++) begin
      sent[d] = 0; vin[d] = 1'b0; acc[d] = 1'b0;
    end
    n = 0;
    while (got_total - got_base < 1000 && n < 30000) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) acc[d] = vin[d] && irdy[d];
      @(posedge clk); #1;
      n++;
      for (int d = 0; d < ND; d++) begin
        target = (d == 0) ? 334 : 333;
        if (!vin[d] || acc[d]) begin
          if (sent[d] < target && $urandom_range(0, 2) != 0) begin
            orig      = {$urandom(), $urandom(), $urandom(), $urandom()};
            din[d]    = mix_model(orig);
            exp_in[d] = orig;
            vin[d]    = 1'b1;
            sent[d]++;
          end else begin
            vin[d] = 1'b0;
          end
        end
        rdy[d] = ($urandom_range(0, 3) != 0);
      end
    end
    chk("roundtrip_count", 128'(got_total - got_base), 128'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
